// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with enable, plus scan, hold and
// single-shot pulse modes. Every output comes from a flop.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   en     - global enable; low clears out/valid/wrap on the next edge
//   mode   - 00 DECODE, 01 SCAN, 10 HOLD, 11 PULSE
//   sel    - decode index (DECODE/PULSE) or load value (SCAN)
//   load   - SCAN: idx <= sel, divider restarts
//   dir    - SCAN direction: 0 up, 1 down
//   out    - registered one-hot (or all-zero) select lines
//   idx    - registered index being decoded or scanned
//   wrap   - one-cycle pulse when a scan step wraps around
//   valid  - high whenever out is non-zero
module decoder_nto2n_seq #(
   parameter int unsigned N        = 3,
   parameter int unsigned SCAN_DIV = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [N-1:0]      sel,
   input  logic              load,
   input  logic              dir,
   output logic [2**N-1:0]   out,
   output logic [N-1:0]      idx,
   output logic              wrap,
   output logic              valid
);

   localparam int unsigned OUTS    = 2**N;
   localparam int unsigned DIV_W   = 16;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [N-1:0]     IDX_MAX  = N'(OUTS - 1);

   typedef enum logic [1:0] {
      M_DECODE = 2'b00,
      M_SCAN   = 2'b01,
      M_HOLD   = 2'b10,
      M_PULSE  = 2'b11
   } mode_e;

   logic [OUTS-1:0]  out_q,   out_d;
   logic [N-1:0]     idx_q,   idx_d;
   logic             wrap_q,  wrap_d;
   logic             valid_q, valid_d;
   logic [DIV_W-1:0] cnt_q,   cnt_d;
   logic             armed_q, armed_d;
   logic [1:0]       mode_q;
   logic             mode_chg;

   function automatic logic [OUTS-1:0] onehot(input logic [N-1:0] i);
      return OUTS'(1) << i;
   endfunction

   // State registers; mode_q remembers last cycle's mode to spot mode changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         mode_q  <= M_DECODE;
      end else begin
         out_q   <= out_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         mode_q  <= mode;
      end
   end

   // Next-state logic for all modes.
   always_comb begin
      out_d    = out_q;
      idx_d    = idx_q;
      wrap_d   = 1'b0;
      cnt_d    = cnt_q;
      armed_d  = 1'b0;
      mode_chg = (mode != mode_q);

      if (!en) begin
         out_d = '0;
      end else begin
         unique case (mode_e'(mode))
            M_DECODE: begin
               idx_d = sel;
               out_d = onehot(sel);
            end
            M_SCAN: begin
               if (load) begin
                  idx_d = sel;
                  cnt_d = '0;
               end else if (mode_chg) begin
                  // Entering scan: keep idx, restart the step divider.
                  cnt_d = '0;
               end else if (cnt_q == DIV_LAST) begin
                  cnt_d = '0;
                  if (!dir) begin
                     idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + N'(1);
                     wrap_d = (idx_q == IDX_MAX);
                  end else begin
                     idx_d  = (idx_q == '0) ? IDX_MAX : idx_q - N'(1);
                     wrap_d = (idx_q == '0);
                  end
               end else begin
                  cnt_d = cnt_q + DIV_W'(1);
               end
               out_d = onehot(idx_d);
            end
            M_HOLD: begin
            end
            M_PULSE: begin
               // One pulse per arming; re-armed by en low or leaving PULSE.
               armed_d = 1'b1;
               if (!armed_q) begin
                  idx_d = sel;
                  out_d = onehot(sel);
               end else begin
                  out_d = '0;
               end
            end
         endcase
      end

      valid_d = (out_d != '0);
   end

   assign out   = out_q;
   assign idx   = idx_q;
   assign wrap  = wrap_q;
   assign valid = valid_q;

endmodule
